axis_packet_framer: RTL
=======================

// Module: axis_packet_framer
// PURPOSE
//  Imposes packet framing on an unframed AXI-Stream (no TLAST) so a downstream packet-mode FIFO can release data.
//  Sits directly upstream of the packetizer stage on the same clock as its input side.
//  Ends a packet when PACKET_BEATS beats have been sent, or when the input has been idle for TIMEOUT cycles.
//  One beat is always held back so TLAST can be attached to the final beat once a packet end is decided.
// PARAMETERS
//  DW            512   tdata width in bits; tkeep is DW/8 bits
//  PACKET_BEATS  64    maximum beats per packet (>=1)
//  TIMEOUT       1024  idle cycles before the held beat is sent with TLAST; 0 disables timeout
// PORTS
//  aclk           in   1     clock for all logic
//  aresetn        in   1     asynchronous, active-low reset
//  s_axis_tdata   in   DW    input data
//  s_axis_tkeep   in   DW/8  input byte enables
//  s_axis_tvalid  in   1     input valid
//  s_axis_tready  out  1     input ready
//  m_axis_tdata   out  DW    output data (registered)
//  m_axis_tkeep   out  DW/8  output byte enables (registered)
//  m_axis_tlast   out  1     end of packet (registered)
//  m_axis_tvalid  out  1     output valid (registered)
//  m_axis_tready  in   1     output ready
//  timeout_flush  out  1     one-cycle pulse when a packet is ended by timeout
// BEHAVIOUR
//  Storage
//   - Hold register H: data, keep and flag hv.
//   - Output register O: drives all m_axis_* signals.
//   - beat_cnt: beats of the current packet already loaded into O (0..PACKET_BEATS-1).
//   - idle_cnt: saturating count of cycles since H was loaded.
//  Reset
//   - While aresetn is low: hv=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0, timeout_flush=0,
//     beat_cnt=0, idle_cnt=0, s_axis_tready=0.
//  Handshake definitions
//   - out_free = !m_axis_tvalid | m_axis_tready.
//   - s_axis_tready = aresetn & (!hv | out_free). Combinational; no combinational path from s_axis_tvalid.
//   - O follows standard AXI rules: once m_axis_tvalid=1, O is stable until m_axis_tready=1.
//   - O is cleared (m_axis_tvalid=0) after handshake unless reloaded in the same cycle.
//  Per-cycle priority
//   1. ACCEPT (s_axis_tvalid & s_axis_tready):
//      - If hv: H->O, tlast = (beat_cnt==PACKET_BEATS-1); beat_cnt = tlast ? 0 : beat_cnt+1.
//      - In all cases: input -> H, hv=1, idle_cnt=0.
//   2. FULL FLUSH (no accept, hv, beat_cnt==PACKET_BEATS-1, out_free):
//      - H->O with tlast=1; hv=0; beat_cnt=0. Does not wait for the timeout.
//   3. TIMEOUT FLUSH (no accept, hv, TIMEOUT!=0, idle_cnt>=TIMEOUT-1, out_free):
//      - H->O with tlast=1; hv=0; beat_cnt=0; timeout_flush=1 for that cycle.
//   4. Otherwise: if hv and idle_cnt<TIMEOUT, idle_cnt++.
//  Timing and latency
//   - A beat accepted on edge E with no successor leaves H on edge E+TIMEOUT when out_free holds;
//     if out_free does not hold, on the first later edge where it does.
//   - Streaming throughput is 1 beat/cycle. Latency is one beat behind input plus one register.
//  Boundary conditions
//   - PACKET_BEATS=1: every beat leaves with tlast=1 via FULL FLUSH one edge after acceptance.
//   - TIMEOUT=0: a partial packet's last beat stays in H indefinitely until the next input beat arrives.
//   - Backpressure: when hv=1 and O is stalled, s_axis_tready=0. No beat is ever dropped or duplicated.
//   - Reset mid-packet discards H and O. No TLAST is emitted for the truncated packet; framing restarts at beat 0.
//   - tkeep passes through unmodified. No beat is generated without input data; no zero-length packets.
// TESTING
//  - PB=4, TO=16, 8 back-to-back beats D0..D7, m_tready=1 -> D0..D7 out in order;
//    tlast on D3 and D7; D7 sent via FULL FLUSH without timeout; timeout_flush never set.
//  - PB=4, TO=16, 3 beats then idle -> tlast on 3rd beat; its m_axis_tvalid rises exactly 16 edges
//    after its acceptance edge; timeout_flush pulses once.
//  - PB=4, TO=16, m_tready=0 for 40 cycles with O and H full -> s_tready=0; timeout_flush deferred
//    until m_tready=1; all beats intact.
//  - PB=4, TO=0, 2 beats then 1000 idle cycles -> only beat 1 out (tlast=0);
//    a 3rd beat then releases beat 2.
//  - Random valid/ready, PB=5, TO=7, 10k beats -> scoreboard data/keep match;
//    tlast placement matches a reference model.
//  - aresetn pulsed low mid-packet (beat 2 of 4) -> outputs 0 immediately;
//    next packet's tlast lands on its 4th beat.

Source files
------------

// File: rtl/axis_packet_framer_if.sv
// ---------------------------------------------------------------------------
// axis_packet_framer_if
//   AXI-Stream bundle used on both sides of the packet framer.
//   Ports / members:
//     tdata  [DW-1:0]    beat data
//     tkeep  [DW/8-1:0]  byte enables
//     tlast              end of packet (only meaningful on the framed side)
//     tvalid             source has a beat
//     tready             sink accepts the beat
//   Modports:
//     master  drives data/keep/last/valid, samples ready
//     slave   samples data/keep/valid, drives ready (input stream is unframed,
//             so tlast is not part of the slave view)
// ---------------------------------------------------------------------------
interface axis_packet_framer_if #(
  parameter int DW = 512
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, output tready);
endinterface

// File: rtl/axis_packet_framer.sv
// ---------------------------------------------------------------------------
// axis_packet_framer
//   Adds TLAST framing to an unframed AXI-Stream. A packet ends after
//   PACKET_BEATS beats, or when the input has been idle for TIMEOUT cycles.
//   One beat is always held back (hold register) so TLAST can be attached to
//   it once the end of the packet is known.
//   Ports:
//     aclk           clock
//     aresetn        asynchronous active-low reset
//     s_axis         unframed input stream (slave modport)
//     m_axis         framed output stream, fully registered (master modport)
//     timeout_flush  one-cycle pulse in the cycle a packet is closed by timeout
// ---------------------------------------------------------------------------
module axis_packet_framer #(
  parameter int DW           = 512,
  parameter int PACKET_BEATS = 64,
  parameter int TIMEOUT      = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axis_packet_framer_if.slave         s_axis,
  axis_packet_framer_if.master        m_axis,
  output logic                        timeout_flush
);

  localparam int KW  = DW / 8;
  localparam int BCW = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;
  localparam int ICW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BCW-1:0] BEAT_LAST = BCW'(PACKET_BEATS - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(TIMEOUT);
  localparam bit             TO_EN     = (TIMEOUT != 0);

  // Hold register
  logic            hv_q, hv_d;
  logic [DW-1:0]   h_data_q, h_data_d;
  logic [KW-1:0]   h_keep_q, h_keep_d;
  // Output register
  logic            o_valid_q, o_valid_d;
  logic            o_last_q, o_last_d;
  logic [DW-1:0]   o_data_q, o_data_d;
  logic [KW-1:0]   o_keep_q, o_keep_d;
  // Framing counters
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;

  logic out_free;
  logic s_ready;
  logic accept;
  logic beat_last;

  assign out_free  = !o_valid_q || m_axis.tready;
  // Ready depends only on state, aresetn and downstream ready, never on tvalid.
  assign s_ready   = aresetn && (!hv_q || out_free);
  assign accept    = s_axis.tvalid && s_ready;
  assign beat_last = (beat_cnt_q == BEAT_LAST);

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = o_valid_q;
  assign m_axis.tlast  = o_last_q;
  assign m_axis.tdata  = o_data_q;
  assign m_axis.tkeep  = o_keep_q;

  always_comb begin
    hv_d          = hv_q;
    h_data_d      = h_data_q;
    h_keep_d      = h_keep_q;
    o_valid_d     = o_valid_q;
    o_last_d      = o_last_q;
    o_data_d      = o_data_q;
    o_keep_d      = o_keep_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_flush = 1'b0;

    // Drained beat leaves O unless O is reloaded below in the same cycle.
    if (o_valid_q && m_axis.tready) begin
      o_valid_d = 1'b0;
    end

    if (accept) begin
      // A new beat pushes the held one out; the held beat closes the packet
      // only if it is the PACKET_BEATS-th one.
      if (hv_q) begin
        o_valid_d  = 1'b1;
        o_data_d   = h_data_q;
        o_keep_d   = h_keep_q;
        o_last_d   = beat_last;
        beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
      end
      hv_d       = 1'b1;
      h_data_d   = s_axis.tdata;
      h_keep_d   = s_axis.tkeep;
      idle_cnt_d = '0;
    end else if (hv_q && beat_last && out_free) begin
      // Packet is full: the held beat is already known to be the last one.
      o_valid_d  = 1'b1;
      o_data_d   = h_data_q;
      o_keep_d   = h_keep_q;
      o_last_d   = 1'b1;
      hv_d       = 1'b0;
      beat_cnt_d = '0;
    end else if (hv_q && TO_EN && (idle_cnt_q >= IDLE_LAST) && out_free) begin
      o_valid_d     = 1'b1;
      o_data_d      = h_data_q;
      o_keep_d      = h_keep_q;
      o_last_d      = 1'b1;
      hv_d          = 1'b0;
      beat_cnt_d    = '0;
      timeout_flush = 1'b1;
    end else if (hv_q && (idle_cnt_q < IDLE_MAX)) begin
      // Saturates at TIMEOUT so a stalled flush stays armed.
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hv_q       <= 1'b0;
      h_data_q   <= '0;
      h_keep_q   <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_data_q   <= '0;
      o_keep_q   <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      hv_q       <= hv_d;
      h_data_q   <= h_data_d;
      h_keep_q   <= h_keep_d;
      o_valid_q  <= o_valid_d;
      o_last_q   <= o_last_d;
      o_data_q   <= o_data_d;
      o_keep_q   <= o_keep_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule
